// File: rtl/iterative_booth_multiplier_module.sv
// iterative_booth_multiplier_module: radix-2 Booth multiplier, one step per clock over WIDTH+1 steps,
// handling signed and unsigned operands through a one-bit operand extension.
module iterative_booth_multiplier_module #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start_Sig,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy_Sig,
    output logic               Done_Sig,
    output logic [2*WIDTH-1:0] Product
);
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);
    typedef enum logic [1:0] {IDLE, BOOTH, DONE} state_t;
    state_t        state;
    logic [E-1:0]  a_ext, s_ext, a_in, b_in, upper;
    logic [2*E:0]  p, p_next;
    logic [CW-1:0] cnt;
    // The extra operand bit lets unsigned values ride through signed Booth recoding.
    always_comb begin
        a_in   = {Signed_Mode & A[WIDTH-1], A};
        b_in   = {Signed_Mode & B[WIDTH-1], B};
        upper  = p[1:0] == 2'b01 ? p[2*E:E+1] + a_ext :
                 p[1:0] == 2'b10 ? p[2*E:E+1] + s_ext : p[2*E:E+1];
        p_next = {upper[E-1], upper, p[E:1]};
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            a_ext    <= '0;
            s_ext    <= '0;
            p        <= '0;
            cnt      <= '0;
            Product  <= '0;
            Done_Sig <= 1'b0;
            Busy_Sig <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start_Sig) begin
                    a_ext    <= a_in;
                    s_ext    <= -a_in;
                    p        <= {{E{1'b0}}, b_in, 1'b0};
                    cnt      <= '0;
                    Busy_Sig <= 1'b1;
                    state    <= BOOTH;
                end
                BOOTH: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(E - 1)) begin
                        Product  <= p_next[2*WIDTH:1];
                        Done_Sig <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    Done_Sig <= 1'b0;
                    Busy_Sig <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_booth_multiplier_module.sv
// tb_iterative_booth_multiplier_module: scoreboard bench driving WIDTH=4, 8 and 16 instances
// from a shared operand bus; only the selected instance sees Start_Sig.
module tb_iterative_booth_multiplier_module;
    logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, sm = 1'b0;
    logic [31:0] a = '0, b = '0;
    int          sel = 8;
    logic        start4, start8, start16, busy4, busy8, busy16, done4, done8, done16;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic        done_sel, busy_sel;
    logic [31:0] prod_sel;
    logic [31:0] exp_q[$];
    int          tests = 0, fails = 0;

    always #5 CLK = ~CLK;

    assign start4   = start && sel == 4;
    assign start8   = start && sel == 8;
    assign start16  = start && sel == 16;
    assign done_sel = sel == 4 ? done4 : sel == 16 ? done16 : done8;
    assign busy_sel = sel == 4 ? busy4 : sel == 16 ? busy16 : busy8;
    assign prod_sel = sel == 4 ? {24'b0, prod4} : sel == 16 ? prod16 : {16'b0, prod8};

    iterative_booth_multiplier_module #(.WIDTH(4)) u4 (
        .CLK(CLK), .RST(RST), .Start_Sig(start4), .Signed_Mode(sm), .A(a[3:0]), .B(b[3:0]),
        .Busy_Sig(busy4), .Done_Sig(done4), .Product(prod4));
    iterative_booth_multiplier_module #(.WIDTH(8)) u8 (
        .CLK(CLK), .RST(RST), .Start_Sig(start8), .Signed_Mode(sm), .A(a[7:0]), .B(b[7:0]),
        .Busy_Sig(busy8), .Done_Sig(done8), .Product(prod8));
    iterative_booth_multiplier_module #(.WIDTH(16)) u16 (
        .CLK(CLK), .RST(RST), .Start_Sig(start16), .Signed_Mode(sm), .A(a[15:0]), .B(b[15:0]),
        .Busy_Sig(busy16), .Done_Sig(done16), .Product(prod16));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    function automatic logic [31:0] model(input int w, input logic [31:0] ai, input logic [31:0] bi, input logic smi);
        longint x, y, r;
        x = longint'(ai) & ((longint'(1) << w) - 1);
        y = longint'(bi) & ((longint'(1) << w) - 1);
        if (smi && ai[w-1]) x -= longint'(1) << w;
        if (smi && bi[w-1]) y -= longint'(1) << w;
        r = x * y;
        return 32'(r & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Start one op, scramble operands after acceptance, and wait (bounded) for Done.
    task automatic run(input int w, input logic [31:0] ai, input logic [31:0] bi, input logic smi,
                       output logic [31:0] prod, output int lat, output int busy_cnt, output logic done_after);
        @(negedge CLK);
        sel = w; a = ai; b = bi; sm = smi; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; a = $urandom; b = $urandom; sm = 1'($urandom_range(0, 1));
        lat = 0;
        busy_cnt = busy_sel ? 1 : 0;
        while (!done_sel && lat < 100) begin
            @(negedge CLK);
            lat++;
            if (busy_sel) busy_cnt++;
        end
        prod = prod_sel;
        @(negedge CLK);
        done_after = done_sel;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        tests++;
        if ({busy4, done4, busy8, done8, busy16, done16} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 000000", {busy4, done4, busy8, done8, busy16, done16});
        end
        tests++;
        if (prod8 !== 16'h0) begin fails++; $display("FAIL reset_prod8: got %h expected 0000", prod8); end
        tests++;
        if ({prod4, prod16} !== 40'h0) begin fails++; $display("FAIL reset_prod4_16: got %h expected 0", {prod4, prod16}); end
        RST = 1'b0;
    endtask

    task automatic test_corners;
        logic [31:0] ta[5], tb_[5], te[5], prod, expv;
        logic        ts[5], da;
        int          lat, bc;
        ta  = '{32'h80, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
        tb_ = '{32'h80, 32'hFF, 32'hFF, 32'h01, 32'h01};
        ts  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        te  = '{32'h4000, 32'hFE01, 32'h0001, 32'hFFFF, 32'h00FF};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(te[i]);
            run(8, ta[i], tb_[i], ts[i], prod, lat, bc, da);
            expv = exp_q.pop_front();
            tests++;
            if (prod !== expv) begin fails++; $display("FAIL corner%0d_product: got %h expected %h", i, prod, expv); end
            tests++;
            if (lat !== 9) begin fails++; $display("FAIL corner%0d_latency: got %0d expected 9", i, lat); end
            tests++;
            if (bc !== 10) begin fails++; $display("FAIL corner%0d_busy_cycles: got %0d expected 10", i, bc); end
            tests++;
            if (da !== 1'b0) begin fails++; $display("FAIL corner%0d_done_width: got %b expected 0", i, da); end
        end
    endtask

    task automatic test_random8;
        logic [31:0] ra, rb, prod, expv;
        logic        rs, da;
        int          lat, bc;
        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            exp_q.push_back(model(8, ra, rb, rs));
            run(8, ra, rb, rs, prod, lat, bc, da);
            expv = exp_q.pop_front();
            tests++;
            if (prod !== expv || lat !== 9) begin
                fails++; $display("FAIL random8: a=%h b=%h s=%b got %h lat %0d expected %h lat 9", ra[7:0], rb[7:0], rs, prod, lat, expv);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n = 0, last = -1;
        @(negedge CLK);
        sel = 8; a = 3; b = 5; sm = 1'b0; start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge CLK);
            if (c == 11) begin
                tests++;
                if (busy8 !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got busy %b expected 0", busy8); end
            end
            if (done8) begin
                tests++;
                if (prod8 !== 16'd15) begin fails++; $display("FAIL b2b_product: got %0d expected 15", prod8); end
                if (last >= 0) begin
                    tests++;
                    if (c - last !== 11) begin fails++; $display("FAIL b2b_period: got %0d expected 11", c - last); end
                end
                last = c;
                n++;
            end
        end
        start = 1'b0;
        tests++;
        if (n !== 3) begin fails++; $display("FAIL b2b_done_count: got %0d expected 3", n); end
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_reset_abort;
        logic [31:0] prod, expv;
        logic        seen = 1'b0, da;
        int          lat, bc;
        @(negedge CLK);
        sel = 8; a = 32'h55; b = 32'h33; sm = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if ({busy8, done8, prod8} !== 18'h0) begin
            fails++; $display("FAIL abort_outputs: got busy %b done %b prod %h expected 0 0 0000", busy8, done8, prod8);
        end
        RST = 1'b0;
        repeat (12) begin @(negedge CLK); if (done8) seen = 1'b1; end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done: got done pulse expected none"); end
        exp_q.push_back(32'h00FE);
        run(8, 32'h7F, 32'h02, 1'b1, prod, lat, bc, da);
        expv = exp_q.pop_front();
        tests++;
        if (prod !== expv) begin fails++; $display("FAIL abort_recover: got %h expected %h", prod, expv); end
        // Reset coinciding with a request must drop the request.
        RST = 1'b1; start = 1'b1;
        @(negedge CLK);
        RST = 1'b0; start = 1'b0;
        @(negedge CLK);
        tests++;
        if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_start_priority: got busy %b expected 0", busy8); end
    endtask

    task automatic test_hold;
        int k = 0;
        exp_q.push_back(32'h00FE);
        @(negedge CLK);
        sel = 8; a = 32'h7F; b = 32'h02; sm = 1'b1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; a = 32'h02; b = 32'h03;
        repeat (3) @(negedge CLK);
        tests++;
        if (prod8 !== 16'h0) begin fails++; $display("FAIL hold_reset_product: got %h expected 0000", prod8); end
        while (!done8 && k < 100) begin @(negedge CLK); k++; end
        tests++;
        if ({16'b0, prod8} !== exp_q.pop_front()) begin fails++; $display("FAIL hold_result: got %h expected 00fe", prod8); end
        @(negedge CLK);
        exp_q.push_back(32'h0006);
        @(negedge CLK);
        a = 32'h02; b = 32'h03; sm = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        tests++;
        if (prod8 !== 16'h00FE) begin fails++; $display("FAIL hold_during_busy: got %h expected 00fe", prod8); end
        k = 0;
        while (!done8 && k < 100) begin @(negedge CLK); k++; end
        tests++;
        if ({16'b0, prod8} !== exp_q.pop_front()) begin fails++; $display("FAIL hold_next: got %h expected 0006", prod8); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_sweep4;
        logic [31:0] prod, expv;
        logic        da;
        int          lat, bc;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    exp_q.push_back(model(4, 32'(x), 32'(y), 1'(s)));
                    run(4, 32'(x), 32'(y), 1'(s), prod, lat, bc, da);
                    expv = exp_q.pop_front();
                    tests++;
                    if (prod !== expv || lat !== 5) begin
                        fails++; $display("FAIL sweep4: a=%0d b=%0d s=%0d got %h lat %0d expected %h lat 5", x, y, s, prod, lat, expv);
                    end
                end
    endtask

    task automatic test_sweep16;
        logic [31:0] ra, rb, prod, expv;
        logic        da;
        int          lat, bc;
        for (int i = 0; i < 80; i++) begin
            ra = i == 0 ? 32'h8000 : $urandom;
            rb = i == 1 ? 32'h8000 : $urandom;
            exp_q.push_back(model(16, ra, rb, 1'(i % 2)));
            run(16, ra, rb, 1'(i % 2), prod, lat, bc, da);
            expv = exp_q.pop_front();
            tests++;
            if (prod !== expv || lat !== 17) begin
                fails++; $display("FAIL sweep16: a=%h b=%h s=%0d got %h lat %0d expected %h lat 17", ra[15:0], rb[15:0], i % 2, prod, lat, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_random8();
        test_back_to_back();
        test_reset_abort();
        test_hold();
        test_sweep4();
        test_sweep16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
